pci_arbiter_rr: RTL and testbench

Parametrised PCI central bus arbiter serving NUM_MASTERS initiators, with selectable round-robin or fixed-priority policy. Includes bus parking, hidden arbitration during an active transaction, and a grant timeout for masters that never start a cycle. It sits beside the PCI bus model and drives the per-master GNT# lines from the REQ#, FRAME# and IRDY# lines, all active-low.

---
 rtl/pci_arb_pkg.sv | 22 ++
 rtl/pci_arb_if.sv | 30 +++
 rtl/pci_arb_picker.sv | 48 ++++
 rtl/pci_arbiter_rr.sv | 191 +++++++++++++++++++
 tb/tb_pci_arbiter_rr.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI central arbiter family.
// Holds the FSM state encoding, the arbitration mode constants and the index-width helper.
package pci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PARKED  = 2'd1,
    GRANTED = 2'd2,
    BUSY    = 2'd3
  } arb_state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Width of a master index; never narrower than one bit.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pci_arb_if.sv
// REQ#/FRAME#/IRDY# in, GNT# and status out, all PCI lines active-low.
// master = arbiter side, slave = bus/initiator side. Inputs are sampled on the rising clk edge.
interface pci_arb_if
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4
);

  localparam int IW = idx_w(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req_n;
  logic                   frame_n;
  logic                   irdy_n;
  logic [NUM_MASTERS-1:0] gnt_n;
  logic [IW-1:0]          owner;
  logic                   bus_idle;
  logic                   timeout_pulse;
  arb_state_t             dbg_state;

  modport master (
    input  req_n, frame_n, irdy_n,
    output gnt_n, owner, bus_idle, timeout_pulse, dbg_state
  );

  modport slave (
    output req_n, frame_n, irdy_n,
    input  gnt_n, owner, bus_idle, timeout_pulse, dbg_state
  );

endinterface

// File: rtl/pci_arb_picker.sv
// Combinational winner picker: round-robin from ptr+1 or fixed lowest-index priority.
// req is active-high here; valid is set whenever any request is present.
module pci_arb_picker
  import pci_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic [IW-1:0] winner,
  output logic          valid
);

  localparam logic [IW+1:0] SUM_N = (IW+2)'(N);

  logic [2*N-1:0] dbl;
  logic [IW:0]    start;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW-1:0]  fx;
  logic [IW+1:0]  sum;
  logic [IW+1:0]  sum_w;

  always_comb begin
    dbl   = {req, req};
    start = {1'b0, ptr} + 1'b1;
    // rot[0] is the request at index ptr+1, wrapping around the doubled vector.
    rot   = dbl[start +: N];

    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum   = {1'b0, start} + {2'b00, off};
    sum_w = (sum >= SUM_N) ? (sum - SUM_N) : sum;

    fx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) fx = IW'(i);
    end

    valid  = |req;
    winner = (mode == MODE_FIXED) ? fx : sum_w[IW-1:0];
  end

endmodule

// File: rtl/pci_arbiter_rr.sv
// PCI central arbiter: round-robin or fixed priority, bus parking, hidden arbitration
// and a grant timeout for masters that never start FRAME#.
module pci_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int FIXED_PRIO  = 0,
  parameter int PARK_EN     = 1,
  parameter int PARK_MASTER = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      reset,
  pci_arb_if.master bus
);

  import pci_arb_pkg::*;

  localparam int IW = idx_w(NUM_MASTERS);
  localparam int CW = $clog2(GNT_TIMEOUT + 1);

  localparam logic [IW-1:0]          PARK_IDX    = IW'(PARK_MASTER);
  localparam logic [CW-1:0]          TO_MAX      = CW'(GNT_TIMEOUT);
  localparam logic [CW-1:0]          TO_LAST     = CW'(GNT_TIMEOUT - 1);
  localparam logic [NUM_MASTERS-1:0] ALL_OFF     = '1;
  localparam logic [NUM_MASTERS-1:0] PARK_ONEHOT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << PARK_MASTER;
  localparam logic                   MODE        = (FIXED_PRIO != 0) ? MODE_FIXED : MODE_RR;

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_n_q, gnt_n_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   bus_idle_q, bus_idle_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   idle;
  logic [IW-1:0]          winner;
  logic                   win_vld;
  logic                   owner_req;
  logic                   others_req;
  logic                   gnt_held;
  logic                   diff_winner;

  function automatic logic [NUM_MASTERS-1:0] gnt_vec(input logic [IW-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  assign req         = ~bus.req_n;
  assign idle        = bus.frame_n & bus.irdy_n;
  assign owner_req   = req[owner_q];
  assign others_req  = |(req & ~PARK_ONEHOT);
  assign gnt_held    = (gnt_n_q != ALL_OFF);
  assign diff_winner = win_vld && (winner != owner_q);

  pci_arb_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .mode   (MODE),
    .winner (winner),
    .valid  (win_vld)
  );

  always_comb begin
    state_d    = state_q;
    gnt_n_d    = gnt_n_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    bus_idle_d = idle;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_n_d = gnt_vec(winner);
          owner_d = winner;
          ptr_d   = winner;
          cnt_d   = '0;
          state_d = GRANTED;
        end else if (PARK_EN != 0) begin
          gnt_n_d = gnt_vec(PARK_IDX);
          owner_d = PARK_IDX;
          state_d = PARKED;
        end
      end

      PARKED: begin
        if (others_req) begin
          gnt_n_d = ALL_OFF;
          state_d = IDLE;
        end else if (!idle) begin
          state_d = BUSY;
        end else if (req[PARK_IDX]) begin
          // Promotion keeps GNT# low; only the bookkeeping of a fresh grant changes.
          ptr_d   = PARK_IDX;
          cnt_d   = '0;
          state_d = GRANTED;
        end
      end

      GRANTED: begin
        if (!bus.frame_n && bus_idle_q) begin
          state_d = BUSY;
        end else if (idle && !owner_req) begin
          gnt_n_d = ALL_OFF;
          state_d = IDLE;
        end else if (idle && (cnt_q == TO_LAST)) begin
          gnt_n_d   = ALL_OFF;
          timeout_d = 1'b1;
          ptr_d     = owner_q;
          cnt_d     = TO_MAX;
          state_d   = IDLE;
        end else if (idle && (cnt_q != TO_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BUSY: begin
        if (gnt_held) begin
          if (diff_winner) begin
            // Hidden arbitration: the running transaction keeps FRAME#, the grant goes now.
            gnt_n_d = ALL_OFF;
          end else if (idle) begin
            if (win_vld) begin
              cnt_d   = '0;
              state_d = GRANTED;
            end else if ((PARK_EN != 0) && (owner_q == PARK_IDX)) begin
              state_d = PARKED;
            end else begin
              gnt_n_d = ALL_OFF;
              state_d = IDLE;
            end
          end
        end else if (idle && bus_idle_q) begin
          // Two consecutive all-high samples guarantee the turnaround cycle.
          if (win_vld) begin
            gnt_n_d = gnt_vec(winner);
            owner_d = winner;
            ptr_d   = winner;
            cnt_d   = '0;
            state_d = GRANTED;
          end else if (PARK_EN != 0) begin
            gnt_n_d = gnt_vec(PARK_IDX);
            owner_d = PARK_IDX;
            state_d = PARKED;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        gnt_n_d = ALL_OFF;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_n_q    <= ALL_OFF;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      bus_idle_q <= 1'b1;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_n_q    <= gnt_n_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      bus_idle_q <= bus_idle_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.gnt_n         = gnt_n_q;
  assign bus.owner         = owner_q;
  assign bus.bus_idle      = bus_idle_q;
  assign bus.timeout_pulse = timeout_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_pci_arbiter_rr.sv
// Directed bench for pci_arbiter_rr: a round-robin instance and a fixed-priority instance
// share clock and reset; expected grants are hand-derived per scenario.
module tb_pci_arbiter_rr;
  import pci_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   onehot_viol = 0;
  int   fx_other = 0;
  bit   fx_watch = 1'b0;

  pci_arb_if #(.NUM_MASTERS(4)) rr_if ();
  pci_arb_if #(.NUM_MASTERS(4)) fx_if ();

  pci_arbiter_rr #(
    .NUM_MASTERS(4), .FIXED_PRIO(0), .PARK_EN(1), .PARK_MASTER(0), .GNT_TIMEOUT(16)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (rr_if.master)
  );

  pci_arbiter_rr #(
    .NUM_MASTERS(4), .FIXED_PRIO(1), .PARK_EN(1), .PARK_MASTER(0), .GNT_TIMEOUT(16)
  ) u_fx (
    .clk   (clk),
    .reset (reset),
    .bus   (fx_if.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if ($countones(~rr_if.gnt_n) > 1 || $countones(~fx_if.gnt_n) > 1) onehot_viol++;
      if (fx_watch && (fx_if.gnt_n[3:1] != 3'b111)) fx_other++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    rr_if.req_n = 4'hF; rr_if.frame_n = 1'b1; rr_if.irdy_n = 1'b1;
    fx_if.req_n = 4'hF; fx_if.frame_n = 1'b1; fx_if.irdy_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_bus(input bit fx, input logic f, input logic i);
    if (fx) begin fx_if.frame_n = f; fx_if.irdy_n = i; end
    else begin rr_if.frame_n = f; rr_if.irdy_n = i; end
  endtask

  // Two data phases: FRAME#+IRDY# low, then IRDY# only, then both released.
  task automatic xfer(input bit fx);
    set_bus(fx, 1'b0, 1'b0);
    @(negedge clk);
    set_bus(fx, 1'b1, 1'b0);
    @(negedge clk);
    set_bus(fx, 1'b1, 1'b1);
  endtask

  task automatic wait_rr_grant(output logic ok, output logic [3:0] prev);
    logic [3:0] last;
    ok   = 1'b0;
    prev = 4'hF;
    last = rr_if.gnt_n;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rr_if.gnt_n != 4'hF) begin
        ok   = 1'b1;
        prev = last;
        break;
      end
      last = rr_if.gnt_n;
    end
  endtask

  logic [3:0] exp_gnt [5] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
  logic [1:0] exp_own [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    logic       ok;
    logic [3:0] prev;
    int         hold_bad;

    idle_inputs();

    // reset values
    repeat (3) @(negedge clk);
    check("rst_gnt", rr_if.gnt_n, 4'b1111);
    check("rst_owner", rr_if.owner, 0);
    check("rst_bus_idle", rr_if.bus_idle, 1);
    check("rst_tmo", rr_if.timeout_pulse, 0);
    check("rst_state", rr_if.dbg_state, IDLE);
    reset = 1'b0;
    @(negedge clk);
    check("park_gnt", rr_if.gnt_n, 4'b1110);
    check("park_owner", rr_if.owner, 0);
    check("park_state", rr_if.dbg_state, PARKED);

    // round-robin fairness with all masters requesting
    rr_if.req_n = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      wait_rr_grant(ok, prev);
      check("rr_seen", ok, 1);
      check("rr_gnt", rr_if.gnt_n, exp_gnt[k]);
      check("rr_owner", rr_if.owner, exp_own[k]);
      check("rr_dead", prev, 4'hF);
      xfer(1'b0);
    end

    // hidden arbitration: master 2 owns, master 3 requests mid-transaction
    do_reset();
    rr_if.req_n = 4'b1011;
    wait_rr_grant(ok, prev);
    check("hid_seen", ok, 1);
    check("hid_gnt2", rr_if.gnt_n, 4'b1011);
    set_bus(1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        check("hid_hold", rr_if.gnt_n, 4'b1011);
        rr_if.req_n = 4'b0011;
      end
      if (c == 3) check("hid_drop", rr_if.gnt_n, 4'b1111);
      if (c == 6) set_bus(1'b0, 1'b1, 1'b1);
    end
    @(negedge clk);
    check("hid_turn", rr_if.gnt_n, 4'b1111);
    @(negedge clk);
    check("hid_gnt3", rr_if.gnt_n, 4'b0111);
    check("hid_owner", rr_if.owner, 3);

    // asynchronous reset in the middle of master 3's transaction
    rr_if.req_n = 4'b0111;
    set_bus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("ar_busy", rr_if.dbg_state, BUSY);
    check("ar_owner3", rr_if.owner, 3);
    #2 reset = 1'b1;
    #1;
    check("ar_gnt", rr_if.gnt_n, 4'b1111);
    check("ar_owner", rr_if.owner, 0);
    check("ar_state", rr_if.dbg_state, IDLE);

    // grant timeout: master 1 never starts, master 2 waits
    do_reset();
    rr_if.req_n = 4'b1001;
    wait_rr_grant(ok, prev);
    check("tmo_seen", ok, 1);
    check("tmo_gnt1", rr_if.gnt_n, 4'b1101);
    hold_bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (rr_if.gnt_n != 4'b1101 || rr_if.timeout_pulse != 1'b0) hold_bad++;
    end
    check("tmo_hold", hold_bad, 0);
    @(negedge clk);
    check("tmo_revoke", rr_if.gnt_n, 4'b1111);
    check("tmo_pulse", rr_if.timeout_pulse, 1);
    @(negedge clk);
    check("tmo_pulse_end", rr_if.timeout_pulse, 0);
    check("tmo_next", rr_if.gnt_n, 4'b1011);
    check("tmo_owner", rr_if.owner, 2);

    // fixed priority: master 0 always wins
    do_reset();
    fx_if.req_n = 4'b0000;
    fx_watch = 1'b1;
    repeat (2) @(negedge clk);
    check("fx_first", fx_if.gnt_n, 4'b1110);
    check("fx_state", fx_if.dbg_state, GRANTED);
    for (int k = 0; k < 3; k++) begin
      xfer(1'b1);
      @(negedge clk);
      check("fx_gnt", fx_if.gnt_n, 4'b1110);
      check("fx_owner", fx_if.owner, 0);
    end
    fx_watch = 1'b0;
    check("fx_others", fx_other, 0);

    check("onehot", onehot_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
